// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, static almost-full/almost-empty
// thresholds, selectable first-word-fall-through read and sticky error flags.
module fifo_sync_param #(
  parameter int ADDSIZE   = 8,
  parameter int DATASIZE  = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 2**ADDSIZE-4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic                afull,
  output logic                aempty,
  output logic [ADDSIZE:0]    count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2**ADDSIZE;
  localparam logic [ADDSIZE:0]   depthc   = (ADDSIZE+1)'(DEPTH);
  localparam logic [ADDSIZE:0]   afullth  = (ADDSIZE+1)'(AFULL_TH);
  localparam logic [ADDSIZE:0]   aemptyth = (ADDSIZE+1)'(AEMPTY_TH);
  localparam logic [ADDSIZE:0]   cntone   = (ADDSIZE+1)'(1);
  localparam logic [ADDSIZE-1:0] addrone  = ADDSIZE'(1);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDSIZE-1:0]  waddr;
  logic [ADDSIZE-1:0]  raddr;
  logic [ADDSIZE:0]    nextcount;
  logic                wen;
  logic                ren;

  // Reset wins over any request in the same cycle, so nothing is accepted then.
  assign wen = winc && !full && !rst;
  assign ren = rinc && !empty && !rst;

  always_comb begin
    nextcount = count;
    if (wen && !ren) begin
      nextcount = count + cntone;
    end else if (ren && !wen) begin
      nextcount = count - cntone;
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
    end else begin
      if (wen) begin
        waddr <= waddr + addrone;
      end
      if (ren) begin
        raddr <= raddr + addrone;
      end
    end
  end

  // Flags come from the next-state count so they are exact right after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count  <= nextcount;
      full   <= (nextcount == depthc);
      empty  <= (nextcount == '0);
      afull  <= (nextcount >= afullth);
      aempty <= (nextcount <= aemptyth);
      if (winc && full) begin
        overflow <= 1'b1;
      end
      if (rinc && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // FWFT presents the head word directly; standard mode registers it on each pop.
  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem[raddr];
    end else begin : g_std
      logic [DATASIZE-1:0] rdreg;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdreg <= '0;
        end else if (ren) begin
          rdreg <= mem[raddr];
        end
      end
      assign rdata = rdreg;
    end
  endgenerate

endmodule
